// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU program loader slice.
//   PROG_ADDR_W    : word-address width of the instruction/data memory port
//   PROG_DATA_W    : memory word width (four bytes)
//   loader_state_t : program loader FSM states
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PROG_ADDR_W = 11;
    localparam int PROG_DATA_W = 32;

    // CHECK is only reachable when PROG_LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
// Groups the program loader's byte stream and memory write port.
//   byte_data/byte_valid : incoming program bytes (driven by the source)
//   byte_ready           : loader accepts a byte this cycle
//   mem_addr/mem_wdata   : memory write address and data
//   mem_wren             : memory write strobe
// Modports:
//   master : the loader side
//   slave  : the byte source / memory side
// ---------------------------------------------------------------------------
interface prog_loader_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DATA_W = PROG_DATA_W
);

    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;

    modport master (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output mem_addr,
        output mem_wdata,
        output mem_wren
    );

    modport slave (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wren
    );

endinterface

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Assembles four bytes into a little-endian 32-bit word: the first byte
// accepted lands in [7:0], the fourth in [31:24].
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : drop any partial word and restart the byte counter
//   byte_en     : a byte is accepted this cycle
//   byte_in     : the byte being accepted
//   word_next   : the word as it will look including the current byte
//   word_valid  : pulses with the fourth byte of a word; word_next is then
//                 the complete word
// ---------------------------------------------------------------------------
module byte_packer
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   byte_en,
    input  logic [7:0]             byte_in,
    output logic [PROG_DATA_W-1:0] word_next,
    output logic                   word_valid
);

    logic [1:0]  count_q;
    logic [23:0] partial_q;

    // Only the three earlier bytes are stored; the fourth is combined on
    // the fly so the word is available in the same cycle it completes.
    assign word_next  = {byte_in, partial_q};
    assign word_valid = byte_en && (count_q == 2'd3);

    // Shift new bytes in from the top so the oldest ends up lowest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 2'd0;
            partial_q <= 24'd0;
        end else if (clear) begin
            count_q   <= 2'd0;
            partial_q <= 24'd0;
        end else if (byte_en) begin
            count_q   <= count_q + 2'd1;
            partial_q <= {byte_in, partial_q[23:8]};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Receives a program as a byte stream, packs it into little-endian words,
// writes them to consecutive memory addresses and then releases the CPU.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN -- a trailing checksum
// byte (XOR of all data bytes) is checked before the CPU is released;
// a mismatch parks the loader in ERROR.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   start          : one-cycle pulse beginning a load (IDLE/DONE/ERROR only)
//   word_count     : number of words to load, sampled on accepted start
//   base_addr      : first word address, sampled on accepted start
//   pc_in          : CPU start PC, sampled on accepted start
//   bus            : byte stream and memory write port (master modport)
//   cpu_rst_n      : active-low CPU reset, released only in DONE
//   start_pc       : PC presented to the CPU
//   busy/done/err  : status flags
// ---------------------------------------------------------------------------
module prog_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DATA_W = PROG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] pc_in,
    prog_loader_if.master     bus,
    output logic              cpu_rst_n,
    output logic [ADDR_W-1:0] start_pc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_t state_q, state_d;

    logic [ADDR_W-1:0] wc_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic                   byte_ready;
    logic                   mem_wren;
    logic                   accept;
    logic                   start_ok;
    logic                   pack_en;
    logic                   last_word;
    logic [PROG_DATA_W-1:0] word_next;
    logic                   word_valid;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
`endif

    assign accept    = bus.byte_valid && byte_ready;
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE) ||
                                 (state_q == ERROR));
    assign pack_en   = accept && (state_q == RECV);
    assign last_word = (index_q == (wc_q - ADDR_W'(1)));

    assign bus.byte_ready = byte_ready;
    assign bus.mem_wren   = mem_wren;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign start_pc       = pc_q;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_en    (pack_en),
        .byte_in    (bus.byte_data),
        .word_next  (word_next),
        .word_valid (word_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs. A zero-length load skips RECV
    // entirely; the CPU stays in reset everywhere except DONE.
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        mem_wren   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst_n  = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                done      = (state_q == DONE);
                cpu_rst_n = (state_q == DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
                err       = (state_q == ERROR);
`endif
                if (start_ok) begin
                    if (word_count == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (word_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy     = 1'b1;
                mem_wren = 1'b1;
                if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (accept) begin
                    state_d = (bus.byte_data == csum_q) ? DONE : ERROR;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load parameters, word index and the memory port registers. The
    // write address and data are captured as the last byte of a word
    // arrives, so they are valid throughout WRITE and hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc_q    <= '0;
            base_q  <= '0;
            pc_q    <= '0;
            index_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (start_ok) begin
                wc_q    <= word_count;
                base_q  <= base_addr;
                pc_q    <= pc_in;
                index_q <= '0;
            end
            if (pack_en && word_valid) begin
                addr_q  <= base_q + index_q;
                wdata_q <= DATA_W'(word_next);
            end
            if ((state_q == WRITE) && !last_word) begin
                index_q <= index_q + ADDR_W'(1);
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR over every data byte of the current load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'd0;
        end else if (start_ok) begin
            csum_q <= 8'd0;
        end else if (pack_en) begin
            csum_q <= csum_q ^ bus.byte_data;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Directed bench for prog_loader. Writes are captured from the memory port
// on the falling edge and compared against hand-computed words/addresses.
// Honours PROG_LOADER_CHECKSUM_EN by sending the trailing checksum byte.
// ---------------------------------------------------------------------------
module tb_prog_loader;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] word_count;
    logic [10:0] base_addr;
    logic [10:0] pc_in;
    logic        cpu_rst_n;
    logic [10:0] start_pc;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader_if bus ();

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .base_addr  (base_addr),
        .pc_in      (pc_in),
        .bus        (bus),
        .cpu_rst_n  (cpu_rst_n),
        .start_pc   (start_pc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          wren_count = 0;
    logic [10:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tb_csum;

    // Capture every memory write cycle away from the active edge.
    always @(negedge clk) begin
        if (bus.mem_wren === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            wren_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"},  32'(bus.byte_ready), 32'd0);
        checkOutput({tag, "_wren"},   32'(bus.mem_wren),   32'd0);
        checkOutput({tag, "_addr"},   32'(bus.mem_addr),   32'd0);
        checkOutput({tag, "_wdata"},  bus.mem_wdata,       32'd0);
        checkOutput({tag, "_cpurst"}, 32'(cpu_rst_n),      32'd0);
        checkOutput({tag, "_pc"},     32'(start_pc),       32'd0);
        checkOutput({tag, "_busy"},   32'(busy),           32'd0);
        checkOutput({tag, "_done"},   32'(done),           32'd0);
        checkOutput({tag, "_err"},    32'(err),            32'd0);
    endtask

    // Called on a falling edge: pulse start for one cycle with load params.
    task automatic applyStimulus(input logic [10:0] wc, input logic [10:0] base,
                                 input logic [10:0] pc);
        wr_addr_q.delete();
        wr_data_q.delete();
        wren_count = 0;
        tb_csum    = 8'd0;
        start      = 1'b1;
        word_count = wc;
        base_addr  = base;
        pc_in      = pc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Offer one byte until the loader takes it; returns on a falling edge.
    task automatic sendByte(input logic [7:0] b);
        int bound;
        bound          = 0;
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        checkOutput("byte_accept", 32'(bus.byte_ready), 32'd1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    // Send a word least-significant byte first; with gap, byte_valid is
    // low for a cycle between bytes and byte_ready must stay up meanwhile.
    task automatic sendWord(input logic [31:0] w, input bit gap);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b       = w[8*i +: 8];
            tb_csum = tb_csum ^ b;
            sendByte(b);
            if (gap) begin
                @(negedge clk);
                if (i < 3) begin
                    checkOutput("ready_hold", 32'(bus.byte_ready), 32'd1);
                end
            end
        end
    endtask

    task automatic waitDone(input string tag);
        int bound;
        bound = 0;
        while (done !== 1'b1 && err !== 1'b1 && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        checkOutput({tag, "_finished"}, 32'(done | err), 32'd1);
    endtask

    task automatic finishLoad(input string tag);
`ifdef PROG_LOADER_CHECKSUM_EN
        sendByte(tb_csum);
`endif
        waitDone(tag);
    endtask

    task automatic expectWrite(input string tag, input logic [10:0] a,
                               input logic [31:0] d);
        if (wr_addr_q.size() > 0) begin
            checkOutput({tag, "_addr"}, 32'(wr_addr_q.pop_front()), 32'(a));
            checkOutput({tag, "_data"}, wr_data_q.pop_front(), d);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        word_count     = '0;
        base_addr      = '0;
        pc_in          = '0;
        bus.byte_data  = 8'd0;
        bus.byte_valid = 1'b0;
        tb_csum        = 8'd0;
        repeat (2) @(negedge clk);
        checkResetValues("por");
        rst = 1'b0;
        @(negedge clk);

        // Two-word program at address 0.
        applyStimulus(11'd2, 11'd0, 11'd0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_cpurst_held", 32'(cpu_rst_n), 32'd0);
        sendWord(32'hE3A00013, 1'b0);
        sendWord(32'hE3A01001, 1'b0);
        finishLoad("t1");
        checkOutput("t1_nwrites", wren_count, 32'd2);
        expectWrite("t1_w0", 11'h000, 32'hE3A00013);
        expectWrite("t1_w1", 11'h001, 32'hE3A01001);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_cpurst", 32'(cpu_rst_n), 32'd1);
        checkOutput("t1_pc", 32'(start_pc), 32'd0);
        checkOutput("t1_wren_low", 32'(bus.mem_wren), 32'd0);
        checkOutput("t1_addr_hold", 32'(bus.mem_addr), 32'h001);
        checkOutput("t1_wdata_hold", bus.mem_wdata, 32'hE3A01001);

        // Address wrap from the top word; a start mid-load is ignored.
        applyStimulus(11'd2, 11'h7FF, 11'h123);
        checkOutput("t2_restart_done", 32'(done), 32'd0);
        sendByte(8'h44);
        tb_csum = tb_csum ^ 8'h44;
        sendByte(8'h33);
        tb_csum = tb_csum ^ 8'h33;
        start      = 1'b1;
        word_count = 11'd5;
        base_addr  = 11'h100;
        pc_in      = 11'h3FF;
        @(negedge clk);
        start = 1'b0;
        sendByte(8'h22);
        tb_csum = tb_csum ^ 8'h22;
        sendByte(8'h11);
        tb_csum = tb_csum ^ 8'h11;
        sendWord(32'h55667788, 1'b0);
        finishLoad("t2");
        checkOutput("t2_nwrites", wren_count, 32'd2);
        expectWrite("t2_w0", 11'h7FF, 32'h11223344);
        expectWrite("t2_w1", 11'h000, 32'h55667788);
        checkOutput("t2_pc", 32'(start_pc), 32'h123);

        // byte_valid toggling every cycle, single word.
        applyStimulus(11'd1, 11'd3, 11'h040);
        sendWord(32'h12345678, 1'b1);
        finishLoad("t3");
        checkOutput("t3_nwrites", wren_count, 32'd1);
        expectWrite("t3_w0", 11'h003, 32'h12345678);
        checkOutput("t3_pc", 32'(start_pc), 32'h040);

        // Zero-length load from IDLE.
        pulseReset();
        applyStimulus(11'd0, 11'd9, 11'h011);
`ifndef PROG_LOADER_CHECKSUM_EN
        checkOutput("t4_done_quick", 32'(done), 32'd1);
`endif
        finishLoad("t4");
        checkOutput("t4_nwrites", wren_count, 32'd0);
        checkOutput("t4_cpurst", 32'(cpu_rst_n), 32'd1);

        // Reset partway through a word discards the partial word.
        applyStimulus(11'd1, 11'h010, 11'h002);
        sendByte(8'hAA);
        sendByte(8'hBB);
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        rst = 1'b0;
        // A byte offered while idle must not be consumed.
        bus.byte_data  = 8'h99;
        bus.byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_ready", 32'(bus.byte_ready), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        bus.byte_valid = 1'b0;
        applyStimulus(11'd1, 11'd5, 11'd7);
        sendWord(32'hEFBEADDE, 1'b0);
        finishLoad("t5");
        checkOutput("t5_nwrites", wren_count, 32'd1);
        expectWrite("t5_w0", 11'h005, 32'hEFBEADDE);
        checkOutput("t5_pc", 32'(start_pc), 32'h007);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum of 01^02^03^04 is 04.
        applyStimulus(11'd1, 11'd0, 11'd0);
        sendWord(32'h04030201, 1'b0);
        sendByte(8'h04);
        waitDone("cs_good");
        checkOutput("cs_good_done", 32'(done), 32'd1);
        checkOutput("cs_good_err", 32'(err), 32'd0);
        applyStimulus(11'd1, 11'd0, 11'd0);
        sendWord(32'h04030201, 1'b0);
        sendByte(8'h05);
        waitDone("cs_bad");
        checkOutput("cs_bad_err", 32'(err), 32'd1);
        checkOutput("cs_bad_done", 32'(done), 32'd0);
        checkOutput("cs_bad_cpurst", 32'(cpu_rst_n), 32'd0);
        applyStimulus(11'd1, 11'd0, 11'd0);
        checkOutput("cs_clear_err", 32'(err), 32'd0);
        checkOutput("cs_clear_busy", 32'(busy), 32'd1);
        pulseReset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
